fpu_result_buffer: RTL and testbench

- Downstream neighbour of the single-cycle FP arithmetic stage.
- Captures each arithmetic result with its destination register tag and exception flags into a 2-entry registered buffer.
- Presents results to the FP register-file writeback port over a valid/ready handshake.
- Keeps the sticky RISC-V fflags accumulator, updated only when a result actually retires (out handshake), plus a CSR read/write path.

---
 rtl/fpu_pkg.sv | 35 +++
 rtl/fpu_skid_fifo.sv | 71 +++++++
 rtl/fpu_result_buffer.sv | 70 +++++++
 tb/tb_fpu_result_buffer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP result writeback path.
// Flag bit positions follow the RISC-V fflags layout.
package fpu_pkg;

  localparam int FLEN_DEF  = 32;
  localparam int RDW_DEF   = 5;
  localparam int FLAGW_DEF = 5;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef struct packed {
    logic [FLEN_DEF-1:0]  data;
    logic [RDW_DEF-1:0]   rd;
    logic [FLAGW_DEF-1:0] flags;
  } fpu_res_t;

  localparam int RES_W = $bits(fpu_res_t);

  function automatic fpu_res_t pack_res(
    input logic [FLEN_DEF-1:0]  data,
    input logic [RDW_DEF-1:0]   rd,
    input logic [FLAGW_DEF-1:0] flags
  );
    fpu_res_t r;
    r.data  = data;
    r.rd    = rd;
    r.flags = flags;
    return r;
  endfunction

endpackage

// File: rtl/fpu_skid_fifo.sv
// Two-entry circular FIFO with registered ready and synchronous flush.
// in_ready depends only on the stored count, never on out_ready.
module fpu_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_payload,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_payload,
  output logic         push,
  output logic         pop
);

  logic [W-1:0] mem [2];
  logic [1:0]   count, count_nx;
  logic         wr_ptr, wr_ptr_nx;
  logic         rd_ptr, rd_ptr_nx;
  logic         full, empty;

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

  assign in_ready    = !full;
  assign out_valid   = !empty;
  assign out_payload = mem[rd_ptr];

  assign push = in_valid & in_ready & !flush;
  assign pop  = out_valid & out_ready & !flush;

  always_comb begin
    count_nx  = count;
    wr_ptr_nx = wr_ptr;
    rd_ptr_nx = rd_ptr;
    if (flush) begin
      count_nx  = 2'd0;
      wr_ptr_nx = 1'b0;
      rd_ptr_nx = 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: count_nx = count + 2'd1;
        2'b01: count_nx = count - 2'd1;
        default: count_nx = count;
      endcase
      if (push) wr_ptr_nx = ~wr_ptr;
      if (pop)  rd_ptr_nx = ~rd_ptr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      count  <= count_nx;
      wr_ptr <= wr_ptr_nx;
      rd_ptr <= rd_ptr_nx;
    end
  end

  // Payload storage is deliberately unreset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_payload;
  end

endmodule

// File: rtl/fpu_result_buffer.sv
// Buffers FP results for register writeback and keeps sticky fflags.
// Flags accumulate only from entries that actually retire.
module fpu_result_buffer
  import fpu_pkg::*;
#(
  parameter int FLEN  = FLEN_DEF,
  parameter int RDW   = RDW_DEF,
  parameter int FLAGW = FLAGW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FLEN-1:0]  in_data,
  input  logic [RDW-1:0]   in_rd,
  input  logic [FLAGW-1:0] in_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FLEN-1:0]  out_data,
  output logic [RDW-1:0]   out_rd,
  output logic [FLAGW-1:0] out_flags,
  input  logic             flush,
  input  logic             csr_we,
  input  logic [FLAGW-1:0] csr_wdata,
  output logic [FLAGW-1:0] fflags
);

  fpu_res_t         in_res, head;
  logic             push, pop;
  logic [FLAGW-1:0] fflags_nx;

  assign in_res = pack_res(in_data, in_rd, in_flags);

  fpu_skid_fifo #(
    .W(RES_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  (in_res),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (head),
    .push        (push),
    .pop         (pop)
  );

  assign out_data  = head.data;
  assign out_rd    = head.rd;
  assign out_flags = head.flags;

  // A CSR write wins, but a same-cycle retirement still ORs in.
  always_comb begin
    fflags_nx = fflags;
    unique case (1'b1)
      csr_we & pop:  fflags_nx = csr_wdata | out_flags;
      csr_we & !pop: fflags_nx = csr_wdata;
      !csr_we & pop: fflags_nx = fflags | out_flags;
      default:       fflags_nx = fflags;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fflags <= '0;
    else        fflags <= fflags_nx;
  end

endmodule

// File: tb/tb_fpu_result_buffer.sv
// Directed bench for fpu_result_buffer.
// Inputs change 1ns after the rising edge; outputs are checked there.
module tb_fpu_result_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_rd, in_flags;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd, out_flags;
  logic        flush, csr_we;
  logic [4:0]  csr_wdata, fflags;

  int tests = 0;
  int fails = 0;

  fpu_result_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_rd     (in_rd),
    .in_flags  (in_flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd    (out_rd),
    .out_flags (out_flags),
    .flush     (flush),
    .csr_we    (csr_we),
    .csr_wdata (csr_wdata),
    .fflags    (fflags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d,
                       input logic [4:0] rd, input logic [4:0] f);
    in_valid = v;
    in_data  = d;
    in_rd    = rd;
    in_flags = f;
  endtask

  task automatic csr_write(input logic [4:0] v);
    csr_we    = 1'b1;
    csr_wdata = v;
    step();
    csr_we    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 5'h0);
    out_ready = 1'b0;
    flush     = 1'b0;
    csr_we    = 1'b0;
    csr_wdata = 5'h0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_fflags", fflags, 0);
    rst_n = 1'b1;
    step();

    // 1.0 + 2.0
    out_ready = 1'b1;
    drive(1'b1, 32'h40400000, 5'd3, 5'h00);
    step();
    drive(1'b0, 32'h0, 5'd0, 5'h0);
    check("add_valid", out_valid, 1);
    check("add_data", out_data, 32'h40400000);
    check("add_rd", out_rd, 3);
    step();
    check("add_drained", out_valid, 0);
    check("add_fflags", fflags, 0);

    // inexact then overflow
    drive(1'b1, 32'h3E99999A, 5'd1, 5'h01);
    step();
    drive(1'b1, 32'h7F800000, 5'd2, 5'h05);
    check("nx_data", out_data, 32'h3E99999A);
    step();
    drive(1'b0, 32'h0, 5'd0, 5'h0);
    check("nx_fflags", fflags, 5'h01);
    check("of_data", out_data, 32'h7F800000);
    check("of_rd", out_rd, 2);
    step();
    check("of_fflags", fflags, 5'h05);
    check("of_drained", out_valid, 0);
    csr_write(5'h00);
    check("csr_clear", fflags, 0);

    // backpressure
    out_ready = 1'b0;
    drive(1'b1, 32'h1, 5'd4, 5'h02);
    step();
    check("bp_ready1", in_ready, 1);
    drive(1'b1, 32'h2, 5'd5, 5'h08);
    step();
    check("bp_ready2", in_ready, 0);
    drive(1'b1, 32'h3, 5'd6, 5'h04);
    step();
    check("bp_full", in_ready, 0);
    check("bp_head", out_data, 32'h1);
    check("bp_rd", out_rd, 4);
    check("bp_fflags_hold", fflags, 0);
    out_ready = 1'b1;
    step();
    check("bp_pop1_fflags", fflags, 5'h02);
    check("bp_pop1_ready", in_ready, 1);
    check("bp_head2", out_data, 32'h2);
    step();
    drive(1'b0, 32'h0, 5'd0, 5'h0);
    check("bp_pop2_fflags", fflags, 5'h0A);
    check("bp_head3", out_data, 32'h3);
    check("bp_rd3", out_rd, 6);
    step();
    check("bp_pop3_fflags", fflags, 5'h0E);
    check("bp_empty", out_valid, 0);
    csr_write(5'h00);

    // flush with two entries buffered
    out_ready = 1'b0;
    drive(1'b1, 32'h7FC00000, 5'd7, 5'h10);
    step();
    step();
    check("fl_full", in_ready, 0);
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 5'h0);
    check("fl_valid", out_valid, 0);
    check("fl_ready", in_ready, 1);
    check("fl_fflags", fflags, 0);
    out_ready = 1'b0;
    drive(1'b1, 32'h55, 5'd9, 5'h00);
    step();
    drive(1'b0, 32'h0, 5'd0, 5'h0);
    check("fl_reuse", out_data, 32'h55);
    check("fl_reuse_rd", out_rd, 9);
    out_ready = 1'b1;
    step();
    check("fl_reuse_pop", out_valid, 0);

    // CSR write colliding with a pop
    csr_write(5'h1F);
    check("csr_set", fflags, 5'h1F);
    out_ready = 1'b0;
    drive(1'b1, 32'h3F800000, 5'd8, 5'h01);
    step();
    drive(1'b0, 32'h0, 5'd0, 5'h0);
    out_ready = 1'b1;
    csr_write(5'h00);
    check("csr_pop", fflags, 5'h01);

    // async reset mid-operation
    csr_write(5'h05);
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 5'd1, 5'h00);
    step();
    step();
    drive(1'b0, 32'h0, 5'd0, 5'h0);
    check("ar_pre_full", in_ready, 0);
    check("ar_pre_fflags", fflags, 5'h05);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_ready", in_ready, 1);
    check("ar_fflags", fflags, 0);
    #2;
    rst_n = 1'b1;
    step();
    check("ar_after", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
